gmii_tx_framer: RTL and testbench
=================================

// Module: gmii_tx_framer
// PURPOSE
//  Ethernet MAC transmit framer driving gmii_txen/gmii_txd of the GMII-to-RGMII converter.
//  Takes a byte stream (dest MAC .. payload, no FCS) with valid/ready/last.
//  Emits preamble and SFD, pads runt frames, appends CRC-32 FCS and enforces the inter-frame gap.
//  Runs entirely in the gmii_txc domain.
// PARAMETERS
//  MIN_LEN  60    min bytes before FCS; shorter frames zero-padded to MIN_LEN (0 = no pad)
//  MAX_LEN  1514  max bytes before FCS; longer frames truncated (see OVERSIZE)
//  IFG_LEN  12    idle cycles after last FCS byte before next preamble
// PORTS
//  gmii_txc      in   1  tx clock, 125 MHz; all logic on rising edge
//  reset         in   1  asynchronous, active-high reset
//  tx_data       in   8  frame byte from upstream
//  tx_valid      in   1  tx_data valid
//  tx_last       in   1  tx_data is final byte of frame
//  tx_ready      out  1  byte accepted when tx_valid & tx_ready
//  gmii_txen     out  1  GMII transmit enable (registered)
//  gmii_txd      out  8  GMII transmit data (registered)
//  busy          out  1  high in any state other than IDLE
//  underrun_err  out  1  one-cycle pulse: tx_valid low mid-frame
//  oversize_err  out  1  one-cycle pulse: frame exceeded MAX_LEN
// BEHAVIOUR
//  Reset (async, immediate): state IDLE, all counters and CRC cleared.
//  All outputs 0 (gmii_txd=8'h00) during reset, including mid-frame; no partial FCS is emitted afterwards.
//  States: IDLE -> PRE -> DATA -> PAD -> FCS -> IFG -> IDLE; DROP is a side branch.
//  IDLE: tx_ready=0; when tx_valid=1, go to PRE next cycle.
//   Data is not consumed in IDLE.
//  PRE: 8 cycles; gmii_txen=1, gmii_txd = 7x 8'h55 then 8'hD5.
//   gmii_txen first rises 1 cycle after tx_valid is seen in IDLE.
//  DATA: tx_ready=1 (combinational from state only).
//   Each accepted byte drives gmii_txd on the next edge, so latency is exactly 1 cycle.
//   Byte count increments per accepted byte; the CRC is updated with that byte.
//   On the accepted tx_last byte: go to PAD if count < MIN_LEN, else go to FCS.
//  UNDERRUN: tx_valid=0 in DATA.
//   Pulse underrun_err, then go to FCS.
//   The transmitted FCS is the bitwise inverse of the correct FCS, so the frame is bad on the wire.
//   No bytes are retried.
//  OVERSIZE: the byte accepted at count==MAX_LEN without tx_last is sent and closes the frame, as if tx_last.
//   Pulse oversize_err and go to FCS, with the correct CRC over the truncated data.
//   If tx_last was not on that byte, go DROP after IFG.
//  DROP: tx_ready=1, gmii_txen=0; consume and discard bytes until an accepted tx_last, then go to IDLE.
//   DROP never starts a frame.
//  PAD: emit 8'h00 with gmii_txen=1 until count==MIN_LEN; CRC covers the pad.
//  FCS: 4 cycles.
//   CRC-32: poly 0x04C11DB7, reflected, init 32'hFFFFFFFF, bitwise LSB-first.
//   FCS = ~crc, sent low byte first: crc[7:0], [15:8], [23:16], [31:24].
//  IFG: gmii_txen=0, gmii_txd=0 for IFG_LEN cycles; tx_valid is ignored.
//   Then go to IDLE (or DROP when an oversize frame is pending).
//  gmii_txen is never high outside PRE/DATA/PAD/FCS.
//   txen is one contiguous pulse per frame: 8 + max(len, MIN_LEN) + 4 cycles.
//  Byte counter is 11 bits and saturates at MAX_LEN; it is cleared in IDLE.
// TESTING
//  1 MIN_LEN=0: send "123456789" (9 bytes)
//    -> txen high 21 cycles: 55x7, D5, 31..39, then 26 39 F4 CB.
//  2 Default params: 14-byte frame -> 46 bytes 00 padding; txen high 72 cycles; FCS matches golden model.
//  3 Back-to-back frames with tx_valid held high -> exactly 12 txen-low cycles between frames; no byte lost.
//  4 Drop tx_valid after 20 bytes -> underrun_err 1 pulse; frame ends with inverted FCS; then 12 IFG cycles.
//  5 MAX_LEN=64, 100-byte frame
//    -> 64 bytes + correct FCS; oversize_err 1 pulse; remaining 36 bytes drained with txen=0; IDLE.
//  6 Assert reset during DATA byte 30
//    -> txen/txd 0 same cycle; after release next frame starts with a full 8-byte preamble.

Source files
------------

// File: rtl/gmii_tx_framer.sv
// Ethernet MAC transmit framer: preamble/SFD, runt padding, CRC-32 FCS and inter-frame gap,
// driving the GMII transmit pins from an upstream byte stream (dest MAC .. payload).
module gmii_tx_framer #(
   parameter int unsigned MIN_LEN = 60,
   parameter int unsigned MAX_LEN = 1514,
   parameter int unsigned IFG_LEN = 12
) (
   input  logic       gmii_txc,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       gmii_txen,
   output logic [7:0] gmii_txd,
   output logic       busy,
   output logic       underrun_err,
   output logic       oversize_err
);

   typedef enum logic [2:0] {
      StIdle, StPre, StData, StPad, StFcs, StIfg, StDrop
   } state_e;

   localparam logic [10:0] MinLen  = 11'(MIN_LEN);
   localparam logic [10:0] MaxLen  = 11'(MAX_LEN);
   localparam logic [15:0] IfgLast = (IFG_LEN == 0) ? 16'd0 : 16'(IFG_LEN - 1);

   state_e      state_q, state_d;
   logic [10:0] cnt_q, cnt_d;       // bytes sent so far (data + pad)
   logic [15:0] cyc_q, cyc_d;       // preamble / FCS byte / IFG cycle counter
   logic [31:0] crc_q, crc_d;
   logic        bad_q, bad_d;       // send the inverted FCS (underrun)
   logic        drop_q, drop_d;     // oversize frame tail still to be drained
   logic        txen_q, txen_d;
   logic [7:0]  txd_q, txd_d;
   logic        underrun_q, underrun_d;
   logic        oversize_q, oversize_d;
   logic [10:0] cnt_inc;
   logic [31:0] fcs;

   // Reflected CRC-32 (poly 0x04C11DB7), one byte processed LSB first
   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         c = (c >> 1) ^ ((c[0] ^ data[i]) ? 32'hEDB88320 : 32'h0);
      end
      return c;
   endfunction

   assign cnt_inc = (cnt_q == MaxLen) ? cnt_q : cnt_q + 11'd1;
   assign fcs     = bad_q ? crc_q : ~crc_q;

   // Next-state, datapath and registered-output next values
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cyc_d      = cyc_q;
      crc_d      = crc_q;
      bad_d      = bad_q;
      drop_d     = drop_q;
      txen_d     = 1'b0;
      txd_d      = 8'h00;
      underrun_d = 1'b0;
      oversize_d = 1'b0;
      tx_ready   = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            cyc_d = '0;
            crc_d = '1;
            bad_d = 1'b0;
            // First preamble byte leaves on the next edge so the gap is exactly IFG_LEN
            if (tx_valid) begin
               txen_d  = 1'b1;
               txd_d   = 8'h55;
               state_d = StPre;
            end
         end
         StPre: begin
            txen_d = 1'b1;
            cyc_d  = cyc_q + 16'd1;
            if (cyc_q == 16'd6) begin
               txd_d   = 8'hD5;
               cyc_d   = '0;
               state_d = StData;
            end else begin
               txd_d = 8'h55;
            end
         end
         StData: begin
            tx_ready = 1'b1;
            if (tx_valid) begin
               txen_d = 1'b1;
               txd_d  = tx_data;
               cnt_d  = cnt_inc;
               crc_d  = crc_byte(crc_q, tx_data);
               if (tx_last) begin
                  state_d = (cnt_inc < MinLen) ? StPad : StFcs;
               end else if (cnt_inc == MaxLen) begin
                  oversize_d = 1'b1;
                  drop_d     = 1'b1;
                  state_d    = StFcs;
               end
            end else begin
               // Underrun: first (inverted) FCS byte goes out now so txen stays contiguous
               underrun_d = 1'b1;
               bad_d      = 1'b1;
               txen_d     = 1'b1;
               txd_d      = crc_q[7:0];
               cyc_d      = 16'd1;
               state_d    = StFcs;
            end
         end
         StPad: begin
            txen_d = 1'b1;
            cnt_d  = cnt_inc;
            crc_d  = crc_byte(crc_q, 8'h00);
            if (cnt_inc >= MinLen) state_d = StFcs;
         end
         StFcs: begin
            txen_d = 1'b1;
            txd_d  = fcs[{cyc_q[1:0], 3'b000} +: 8];
            cyc_d  = cyc_q + 16'd1;
            if (cyc_q[1:0] == 2'd3) begin
               cyc_d   = '0;
               state_d = StIfg;
            end
         end
         StIfg: begin
            cyc_d = cyc_q + 16'd1;
            if (cyc_q >= IfgLast) begin
               cyc_d   = '0;
               drop_d  = 1'b0;
               state_d = drop_q ? StDrop : StIdle;
            end
         end
         StDrop: begin
            tx_ready = 1'b1;
            if (tx_valid && tx_last) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and registered GMII outputs, cleared immediately by reset
   always_ff @(posedge gmii_txc or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         cyc_q      <= '0;
         crc_q      <= '0;
         bad_q      <= 1'b0;
         drop_q     <= 1'b0;
         txen_q     <= 1'b0;
         txd_q      <= 8'h00;
         underrun_q <= 1'b0;
         oversize_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cyc_q      <= cyc_d;
         crc_q      <= crc_d;
         bad_q      <= bad_d;
         drop_q     <= drop_d;
         txen_q     <= txen_d;
         txd_q      <= txd_d;
         underrun_q <= underrun_d;
         oversize_q <= oversize_d;
      end
   end

   assign gmii_txen    = txen_q;
   assign gmii_txd     = txd_q;
   assign busy         = (state_q != StIdle);
   assign underrun_err = underrun_q;
   assign oversize_err = oversize_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Self-checking bench for gmii_tx_framer: directed scenarios plus random frames, compared
// against a frame-level reference model of the wire bytes.
module tb_gmii_tx_framer;

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid, tx_last;
   logic       sel;

   logic       rdy_a, txen_a, busy_a, und_a, ovf_a;
   logic [7:0] txd_a;
   logic       rdy_b, txen_b, busy_b, und_b, ovf_b;
   logic [7:0] txd_b;
   logic       m_rdy, m_txen, m_busy, m_und, m_ovf;
   logic [7:0] m_txd;

   int checks   = 0;
   int failures = 0;

   always #4 clk = ~clk;

   // Main instance: MIN_LEN 60, MAX_LEN 64
   gmii_tx_framer #(.MIN_LEN(60), .MAX_LEN(64), .IFG_LEN(12)) u_dut (
      .gmii_txc(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_last(tx_last), .tx_ready(rdy_a), .gmii_txen(txen_a), .gmii_txd(txd_a),
      .busy(busy_a), .underrun_err(und_a), .oversize_err(ovf_a)
   );

   // No-padding instance
   gmii_tx_framer #(.MIN_LEN(0), .MAX_LEN(1514), .IFG_LEN(12)) u_dut_nopad (
      .gmii_txc(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_last(tx_last), .tx_ready(rdy_b), .gmii_txen(txen_b), .gmii_txd(txd_b),
      .busy(busy_b), .underrun_err(und_b), .oversize_err(ovf_b)
   );

   assign m_rdy  = sel ? rdy_b  : rdy_a;
   assign m_txen = sel ? txen_b : txen_a;
   assign m_txd  = sel ? txd_b  : txd_a;
   assign m_busy = sel ? busy_b : busy_a;
   assign m_und  = sel ? und_b  : und_a;
   assign m_ovf  = sel ? ovf_b  : ovf_a;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

   // Non-reflected MSB-first CRC on bit-reversed bytes, result reversed back
   function automatic logic [31:0] fcs_of(input bq_t f);
      logic [31:0] c;
      logic [31:0] r;
      c = 32'hFFFFFFFF;
      foreach (f[i]) begin
         c = c ^ {rev8(f[i]), 24'h0};
         for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
      end
      for (int i = 0; i < 32; i++) r[i] = c[31-i];
      return ~r;
   endfunction

   function automatic bq_t expect_wire(input bq_t pl, input int min_len, input int max_len,
                                       input bit und);
      bq_t f;
      bq_t w;
      logic [31:0] fcs;
      for (int i = 0; i < pl.size() && i < max_len; i++) f.push_back(pl[i]);
      if (!und) while (f.size() < min_len) f.push_back(8'h00);
      fcs = fcs_of(f);
      if (und) fcs = ~fcs;
      for (int i = 0; i < 7; i++) w.push_back(8'h55);
      w.push_back(8'hD5);
      foreach (f[i]) w.push_back(f[i]);
      for (int k = 0; k < 4; k++) w.push_back(fcs[8*k +: 8]);
      return w;
   endfunction

   function automatic int first_diff(input bq_t a, input bq_t b);
      int n;
      n = (a.size() < b.size()) ? a.size() : b.size();
      for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
      if (a.size() != b.size()) return n;
      return -1;
   endfunction

   function automatic bq_t rand_payload(input int n);
      bq_t p;
      for (int i = 0; i < n; i++) p.push_back(8'($urandom));
      return p;
   endfunction

   // ---------------- monitor ----------------
   bq_t cap;
   int  burst_len[$];
   int  gaps[$];
   int  cur_len = 0, low_run = 0, und_cnt = 0, ovf_cnt = 0;
   bit  seen_burst = 0;

   always @(negedge clk) begin
      if (m_txen) begin
         if (cur_len == 0 && seen_burst) gaps.push_back(low_run);
         cap.push_back(m_txd);
         cur_len++;
      end else begin
         if (cur_len != 0) begin
            burst_len.push_back(cur_len);
            cur_len    = 0;
            seen_burst = 1;
            low_run    = 0;
         end
         low_run++;
      end
      if (m_und) und_cnt++;
      if (m_ovf) ovf_cnt++;
   end

   task automatic clear_mon();
      cap.delete();
      burst_len.delete();
      gaps.delete();
      cur_len    = 0;
      low_run    = 0;
      und_cnt    = 0;
      ovf_cnt    = 0;
      seen_burst = 0;
   endtask

   // ---------------- driver ----------------
   bq_t d_q;
   bit  l_q[$];
   int  accepted;

   task automatic load(input bq_t pl, input bit append);
      if (!append) begin
         d_q.delete();
         l_q.delete();
      end
      foreach (pl[i]) begin
         d_q.push_back(pl[i]);
         l_q.push_back(i == pl.size() - 1);
      end
   endtask

   // stop_after: drop tx_valid after that many bytes; reset_at: pulse reset at that byte
   task automatic drive(input string tag, input int stop_after, input int reset_at);
      int idx    = 0;
      int budget = 0;
      int target;
      target   = (stop_after >= 0) ? stop_after : (reset_at >= 0) ? reset_at : d_q.size();
      accepted = 0;
      while (idx < d_q.size() && budget < 5000) begin
         @(negedge clk);
         budget++;
         if (stop_after >= 0 && idx == stop_after) begin
            tx_valid = 1'b0;
            tx_last  = 1'b0;
            break;
         end
         if (reset_at >= 0 && idx == reset_at) begin
            check({tag, "_txen_before_reset"}, m_txen, 1);
            #2 reset = 1'b1;
            #1;
            tx_valid = 1'b0;
            tx_last  = 1'b0;
            check({tag, "_reset_txen"}, m_txen, 0);
            check({tag, "_reset_txd"}, m_txd, 0);
            check({tag, "_reset_busy"}, m_busy, 0);
            @(negedge clk);
            reset = 1'b0;
            break;
         end
         tx_valid = 1'b1;
         tx_data  = d_q[idx];
         tx_last  = l_q[idx];
         if (m_rdy) begin
            idx++;
            accepted++;
         end
      end
      @(negedge clk);
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      check({tag, "_accepted"}, accepted, target);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((m_busy || m_txen) && n < 4000) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check({tag, "_idle_timeout"}, (n < 4000), 1);
   endtask

   task automatic check_frame(input string tag, input bq_t ex, input int nb);
      check({tag, "_bursts"}, burst_len.size(), nb);
      check({tag, "_bytes"}, first_diff(cap, ex), -1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bq_t pl, pl2, ex, ex2;
      int  len, oversz;
      logic [31:0] tail;

      reset = 1'b1; sel = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_txen", m_txen, 0);
      check("rst_txd", m_txd, 0);
      check("rst_busy", m_busy, 0);
      check("rst_ready", m_rdy, 0);
      check("rst_errs", {m_und, m_ovf}, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_ready", m_rdy, 0);
      check("idle_busy", m_busy, 0);

      // "123456789" without padding
      sel = 1'b1;
      pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      clear_mon(); load(pl, 0); drive("t1", -1, -1); wait_idle("t1");
      check_frame("t1", expect_wire(pl, 0, 1514, 0), 1);
      check("t1_len", (burst_len.size() > 0) ? burst_len[0] : -1, 21);
      tail = 32'h0;
      if (cap.size() == 21) tail = {cap[20], cap[19], cap[18], cap[17]};
      check("t1_golden_fcs", tail, 32'hCBF43926);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sel   = 1'b0;
      repeat (2) @(negedge clk);

      // 14-byte runt padded to 60
      pl = rand_payload(14);
      clear_mon(); load(pl, 0); drive("t2", -1, -1); wait_idle("t2");
      check_frame("t2", expect_wire(pl, 60, 64, 0), 1);
      check("t2_len", (burst_len.size() > 0) ? burst_len[0] : -1, 72);

      // Back-to-back frames with tx_valid held high
      pl = rand_payload(20); pl2 = rand_payload(62);
      clear_mon(); load(pl, 0); load(pl2, 1); drive("t3", -1, -1); wait_idle("t3");
      ex = expect_wire(pl, 60, 64, 0); ex2 = expect_wire(pl2, 60, 64, 0);
      foreach (ex2[i]) ex.push_back(ex2[i]);
      check_frame("t3", ex, 2);
      check("t3_gap", (gaps.size() > 0) ? gaps[0] : -1, 12);

      // Underrun after 20 bytes, then a follow-up frame
      pl = rand_payload(40); pl2 = rand_payload(61);
      clear_mon(); load(pl, 0); drive("t4", 20, -1);
      load(pl2, 0); drive("t4b", -1, -1); wait_idle("t4");
      ex = expect_wire(pl[0:19], 60, 64, 1); ex2 = expect_wire(pl2, 60, 64, 0);
      foreach (ex2[i]) ex.push_back(ex2[i]);
      check_frame("t4", ex, 2);
      check("t4_len", (burst_len.size() > 0) ? burst_len[0] : -1, 32);
      check("t4_underrun_pulses", und_cnt, 1);
      check("t4_gap", (gaps.size() > 0) ? gaps[0] : -1, 12);

      // Oversize 100-byte frame, truncated at 64 and drained
      pl = rand_payload(100);
      clear_mon(); load(pl, 0); drive("t5", -1, -1); wait_idle("t5");
      check_frame("t5", expect_wire(pl, 60, 64, 0), 1);
      check("t5_oversize_pulses", ovf_cnt, 1);
      check("t5_busy_after", m_busy, 0);

      // Reset during data byte 30, then a fresh frame
      pl = rand_payload(50);
      clear_mon(); load(pl, 0); drive("t6", -1, 30);
      repeat (2) @(negedge clk);
      check("t6_busy_after_reset", m_busy, 0);
      pl = rand_payload(61);
      clear_mon(); load(pl, 0); drive("t6b", -1, -1); wait_idle("t6b");
      check_frame("t6b", expect_wire(pl, 60, 64, 0), 1);

      // Random frame lengths around pad and truncation limits
      for (int n = 0; n < 6; n++) begin
         len    = $urandom_range(80, 1);
         oversz = (len > 64) ? 1 : 0;
         pl     = rand_payload(len);
         clear_mon(); load(pl, 0); drive("rnd", -1, -1); wait_idle("rnd");
         check_frame("rnd", expect_wire(pl, 60, 64, 0), 1);
         check("rnd_oversize", ovf_cnt, oversz);
         check("rnd_underrun", und_cnt, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
